qpsk_symbol_scheduler: RTL and testbench

QPSK_SYMBOL_SCHEDULER -- requirements
Module: qpsk_symbol_scheduler

---
 rtl/qpsk_symbol_scheduler.sv | 259 +++++++++++++++++++++++++
 tb/tb_qpsk_symbol_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_scheduler.sv
// qpsk_symbol_scheduler
// Holds QPSK symbols in a small FIFO and plays each one for SYM_LEN NCO samples.
// The NCO frequency word and sign select are reloaded only at symbol boundaries.
// The per-sample I/Q sign flags go through a PIPE_LAT-deep delay line, so they
// line up with the NCO output samples.
// Compile-time option: define QPSK_GRAY_MAP_EN to select the Gray symbol map.
// Without it, the natural map is used (I_neg = b1, Q_neg = b0).
//
// state | meaning
// IDLE  | not playing; FIFO accepts symbols; waits for start
// RUN   | playing symbols; waits with nco_En low while the FIFO is empty
// DRAIN | stop honoured; waits until every issued NCO sample has come back
module qpsk_symbol_scheduler #(
    parameter int FCW_W      = 20,
    parameter int SYM_LEN    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sym_valid,
    input  logic [1:0]       sym_data,
    output logic             sym_ready,
    input  logic             cfg_we,
    input  logic [FCW_W-1:0] cfg_fcw,
    input  logic             cfg_sign,
    output logic             nco_En,
    output logic [FCW_W-1:0] nco_FCW,
    output logic             nco_selSign,
    input  logic             nco_VldX,
    output logic             out_vld,
    output logic             out_I_neg,
    output logic             out_Q_neg,
    output logic             busy,
    output logic             underrun,
    output logic             err
);

    // FIFO_DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int OW = $clog2(PIPE_LAT + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             sym_act_q, sym_act_d;
    logic [1:0]       sym_cur_q, sym_cur_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             underrun_q, underrun_d;
    logic             err_q, err_d;
    logic [OW-1:0]    out_q, out_d;
    logic [FCW_W-1:0] fcw_sh_q, fcw_q;
    logic             sign_sh_q, sign_q;

    logic [1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      fifo_cnt_q;
    logic             fifo_empty, fifo_full;
    logic [1:0]       fifo_head;

    logic             pop, push, bypass, load;
    logic             i_neg, q_neg;
    logic [2:0]       pipe_q [PIPE_LAT];

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // A full FIFO still takes a push in the same cycle as a pop.
    // A symbol that bypasses the FIFO is not written into it.
    assign push = sym_valid && (!fifo_full || pop) && !bypass;

    assign nco_En      = (state_q == S_RUN) && sym_act_q;
    assign nco_FCW     = fcw_q;
    assign nco_selSign = sign_q;
    assign sym_ready   = !fifo_full;
    assign busy        = (state_q != S_IDLE);
    assign underrun    = underrun_q;
    assign err         = err_q;

`ifdef QPSK_GRAY_MAP_EN
    assign i_neg = sym_cur_q[0];
    assign q_neg = sym_cur_q[1];
`else
    assign i_neg = sym_cur_q[1];
    assign q_neg = sym_cur_q[0];
`endif

    // Outstanding NCO samples. VldX with nothing outstanding is flagged as an error.
    always_comb begin
        out_d = out_q;
        err_d = err_q;
        if (nco_VldX && out_q == '0) begin
            err_d = 1'b1;
        end
        unique case ({nco_En, nco_VldX})
            2'b10:   if (out_q != '1) out_d = out_q + OW'(1);
            2'b01:   if (out_q != '0) out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // Next-state logic: symbol sequencing, FIFO pop or bypass, shadow reload.
    always_comb begin
        state_d    = state_q;
        sym_act_d  = sym_act_q;
        sym_cur_d  = sym_cur_q;
        cnt_d      = cnt_q;
        stop_d     = stop_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        bypass     = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    load    = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        sym_act_d = 1'b1;
                        sym_cur_d = fifo_head;
                    end else begin
                        sym_act_d  = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop) stop_d = 1'b1;
                if (sym_act_q) begin
                    if (cnt_q == CW'(SYM_LEN - 1)) begin
                        cnt_d = '0;
                        if (stop_q || stop) begin
                            state_d   = S_DRAIN;
                            sym_act_d = 1'b0;
                            stop_d    = 1'b0;
                        end else if (!fifo_empty) begin
                            pop       = 1'b1;
                            load      = 1'b1;
                            sym_cur_d = fifo_head;
                        end else begin
                            sym_act_d  = 1'b0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // No symbol is current, so this cycle is a symbol boundary.
                    if (stop_q || stop) begin
                        state_d = S_DRAIN;
                        stop_d  = 1'b0;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        sym_act_d = 1'b1;
                        sym_cur_d = fifo_head;
                        cnt_d     = '0;
                    end else if (sym_valid) begin
                        bypass    = 1'b1;
                        load      = 1'b1;
                        sym_act_d = 1'b1;
                        sym_cur_d = sym_data;
                        cnt_d     = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (out_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registers for the control state, the counters and the sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sym_act_q  <= 1'b0;
            sym_cur_q  <= '0;
            cnt_q      <= '0;
            stop_q     <= 1'b0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            sym_act_q  <= sym_act_d;
            sym_cur_q  <= sym_cur_d;
            cnt_q      <= cnt_d;
            stop_q     <= stop_d;
            underrun_q <= underrun_d;
            err_q      <= err_d;
            out_q      <= out_d;
        end
    end

    // Config shadows are written at any time; the NCO drive copies them only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw_sh_q  <= '0;
            sign_sh_q <= 1'b0;
            fcw_q     <= '0;
            sign_q    <= 1'b0;
        end else begin
            if (cfg_we) begin
                fcw_sh_q  <= cfg_fcw;
                sign_sh_q <= cfg_sign;
            end
            if (load) begin
                fcw_q  <= fcw_sh_q;
                sign_q <= sign_sh_q;
            end
        end
    end

    // Symbol FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sym_data;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Delay line that aligns {En, I_neg, Q_neg} with the NCO output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {nco_En, nco_En & i_neg, nco_En & q_neg};
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_vld   = pipe_q[PIPE_LAT-1][2];
    assign out_I_neg = pipe_q[PIPE_LAT-1][1];
    assign out_Q_neg = pipe_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Testbench for qpsk_symbol_scheduler. The NCO model returns VldX PIPE_LAT
// cycles after En. Expected I/Q sign pairs are queued when symbols are pushed
// and are checked in order against out_I_neg/out_Q_neg.
module tb_qpsk_symbol_scheduler;

    localparam int FCW_W      = 20;
    localparam int SYM_LEN    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int PIPE_LAT   = 9;

    logic             clk;
    logic             rst_n;
    logic             start, stop;
    logic             sym_valid;
    logic [1:0]       sym_data;
    logic             sym_ready;
    logic             cfg_we;
    logic [FCW_W-1:0] cfg_fcw;
    logic             cfg_sign;
    logic             nco_En;
    logic [FCW_W-1:0] nco_FCW;
    logic             nco_selSign;
    logic             nco_VldX;
    logic             out_vld, out_I_neg, out_Q_neg;
    logic             busy, underrun, err;

    logic                force_vldx;
    logic [PIPE_LAT-1:0] vld_sr;
    logic [1:0]          exp_q [$];
    logic [1:0]          mon_e;
    int                  n_checks;
    int                  n_errors;
    int                  n;

    qpsk_symbol_scheduler #(
        .FCW_W(FCW_W), .SYM_LEN(SYM_LEN), .FIFO_DEPTH(FIFO_DEPTH), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .cfg_we(cfg_we), .cfg_fcw(cfg_fcw), .cfg_sign(cfg_sign),
        .nco_En(nco_En), .nco_FCW(nco_FCW), .nco_selSign(nco_selSign),
        .nco_VldX(nco_VldX),
        .out_vld(out_vld), .out_I_neg(out_I_neg), .out_Q_neg(out_Q_neg),
        .busy(busy), .underrun(underrun), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NCO model: a fixed-latency valid that can be forced high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[PIPE_LAT-2:0], nco_En};
    end
    assign nco_VldX = vld_sr[PIPE_LAT-1] | force_vldx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [1:0] map_sym(input logic [1:0] s);
`ifdef QPSK_GRAY_MAP_EN
        return {s[0], s[1]};
`else
        return {s[1], s[0]};
`endif
    endfunction

    task automatic sb_push(input logic [1:0] s);
        for (int k = 0; k < SYM_LEN; k++) exp_q.push_back(map_sym(s));
    endtask

    // Check the output side: valid alignment, and the sign flags against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("out_vld_align", out_vld, vld_sr[PIPE_LAT-1]);
            if (out_vld) begin
                check_val("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("out_iq", {out_I_neg, out_Q_neg}, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; sym_valid = 1'b0; sym_data = '0;
        cfg_we = 1'b0; cfg_fcw = '0; cfg_sign = 1'b0; force_vldx = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic count_en(input int max, output int cnt);
        cnt = 0;
        while (nco_En && cnt < max) begin
            cnt++;
            tick();
        end
    endtask

    task automatic push_sym(input logic [1:0] s);
        sym_valid = 1'b1; sym_data = s;
        sb_push(s);
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic stop_and_drain(input string tag);
        int k;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        k = 0;
        while (busy && k < 60) begin
            k++;
            tick();
        end
        check_val(tag, busy, 0);
        check_val("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset values.
        do_reset();
        check_val("rst_nco_En", nco_En, 0);
        check_val("rst_nco_FCW", nco_FCW, 0);
        check_val("rst_selSign", nco_selSign, 0);
        check_val("rst_out", {out_vld, out_I_neg, out_Q_neg}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_err", err, 0);
        check_val("rst_sym_ready", sym_ready, 1);

        // Single symbol, then underrun, then resume on a push.
        cfg_we = 1'b1; cfg_fcw = 20'h01000; cfg_sign = 1'b1;
        push_sym(2'b01);
        cfg_we = 1'b0;
        check_val("cfg_no_immediate", nco_FCW, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("t1_first_en", nco_En, 1);
        check_val("t1_first_fcw", nco_FCW, 20'h01000);
        check_val("t1_first_sign", nco_selSign, 1);
        check_val("t1_busy", busy, 1);
        count_en(100, n);
        check_val("t1_en_len", n, SYM_LEN);
        check_val("t1_underrun", underrun, 1);
        repeat (3) tick();
        check_val("t1_wait_en", nco_En, 0);
        push_sym(2'b10);
        check_val("t1_resume_en", nco_En, 1);
        count_en(100, n);
        check_val("t1_resume_len", n, SYM_LEN);
        stop_and_drain("t1_idle");

        // Fill the FIFO, stream 64 samples, and change the config mid-symbol.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sym_valid = 1'b1;
            sym_data  = 2'(i);
            check_val("t2_sym_ready", sym_ready, (i < 4) ? 1 : 0);
            if (i < 4) sb_push(2'(i));
            tick();
        end
        sym_valid = 1'b0;
        cfg_we = 1'b1; cfg_fcw = 20'h01000; cfg_sign = 1'b0;
        tick();
        cfg_we = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4 * SYM_LEN; i++) begin
            check_val("t2_en_cont", nco_En, 1);
            if (i == 0)  check_val("t2_fcw_first", nco_FCW, 20'h01000);
            if (i == 31) check_val("t2_fcw_hold", nco_FCW, 20'h01000);
            if (i == 32) check_val("t2_fcw_boundary", nco_FCW, 20'h00800);
            if (i == 21) begin
                cfg_we = 1'b1; cfg_fcw = 20'h00800;
            end else begin
                cfg_we = 1'b0;
            end
            tick();
        end
        cfg_we = 1'b0;
        check_val("t2_en_after", nco_En, 0);
        check_val("t2_underrun", underrun, 1);
        stop_and_drain("t2_idle");

        // Stop at sample 3, DRAIN timing, start ignored in DRAIN, queued symbols kept.
        do_reset();
        cfg_we = 1'b1; cfg_fcw = 20'h00400; cfg_sign = 1'b1;
        push_sym(2'b11);
        cfg_we = 1'b0;
        push_sym(2'b01);
        push_sym(2'b10);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < SYM_LEN; i++) begin
            check_val("t3_en", nco_En, 1);
            stop = (i == 3);
            tick();
        end
        stop = 1'b0;
        check_val("t3_en_off", nco_En, 0);
        for (int k = 1; k <= PIPE_LAT; k++) begin
            check_val("t3_busy_drain", busy, 1);
            check_val("t3_en_drain", nco_En, 0);
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        check_val("t3_busy_fall", busy, 0);
        check_val("t3_underrun", underrun, 0);
        check_val("t3_ready", sym_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        count_en(100, n);
        check_val("t3_remaining", n, 2 * SYM_LEN);
        check_val("t3_underrun_end", underrun, 1);
        stop_and_drain("t3_idle");

        // Reset while a symbol is playing aborts at once.
        do_reset();
        push_sym(2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_val("t4_pre_en", nco_En, 1);
        rst_n = 1'b0;
        #1;
        check_val("t4_abort_en", nco_En, 0);
        check_val("t4_abort_busy", busy, 0);
        check_val("t4_abort_out", out_vld, 0);

        // VldX with nothing outstanding sets a sticky error.
        do_reset();
        check_val("t5_err_clear", err, 0);
        force_vldx = 1'b1;
        tick();
        force_vldx = 1'b0;
        check_val("t5_err_set", err, 1);
        repeat (5) tick();
        check_val("t5_err_sticky", err, 1);
        do_reset();
        check_val("t5_err_reset", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
